pp_stream_merger: RTL and testbench
===================================

// Module: pp_stream_merger
// PURPOSE
//  Downstream consumer of the dual-stream packet counter. Merges the two AXIS
//  streams (path 1 / path 2) into one output stream in ping-pong order:
//  PP_GROUP packets of PACKET_SIZE beats from input 1, then PP_GROUP from input 2,
//  and so on. Adds packet (tlast) and frame-start (tuser) framing and counts frames.
// PARAMETERS
//  DW           128  data width, all streams
//  PP_GROUP     2    packets taken from one input before switching
//  PACKET_SIZE  2    beats per packet
//  FRAME_SIZE   256  output beats per frame; must be a multiple of PACKET_SIZE
// PORTS
//  clk              in   1    clock
//  resetn           in   1    synchronous, active-low reset
//  axis_in1_tdata   in   DW   input stream 1 data
//  axis_in1_tvalid  in   1    input stream 1 valid
//  axis_in1_tready  out  1    input stream 1 ready
//  axis_in2_tdata   in   DW   input stream 2 data
//  axis_in2_tvalid  in   1    input stream 2 valid
//  axis_in2_tready  out  1    input stream 2 ready
//  axis_out_tdata   out  DW   merged data
//  axis_out_tvalid  out  1    merged valid
//  axis_out_tready  in   1    merged ready
//  axis_out_tlast   out  1    last beat of packet
//  axis_out_tuser   out  1    first beat of frame
//  frame_count      out  32   completed output frames, wraps at 2^32
// BEHAVIOUR
//  - Reset (resetn=0 at clk edge): both skid buffers empty; in1/in2_tready=0
//    during reset, 1 the first cycle after; out_tvalid/tlast/tuser=0,
//    out_tdata=0; frame_count=0; all counters 0; FSM=S_IN1.
//  - Reset mid-operation discards all buffered and in-flight beats; no beat
//    completes on the reset edge.
//  - Each input has a 2-entry skid buffer; tready = buffer not full (registered).
//    Empty buffer is pass-through (no added cycle). Beat accepted iff tvalid&&tready.
//  - Output register: 1 stage. Loaded from the selected buffer when it holds a
//    beat and (out_tvalid==0 || out_tready==1). Latency input accept -> out_tvalid
//    = 1 cycle; sustained throughput 1 beat/cycle.
//  - AXIS rule: while out_tvalid && !out_tready, tdata/tlast/tuser hold stable.
//  - FSM states S_IN1, S_IN2. Switch only on the output-side transfer of the last
//    beat of the PP_GROUP-th packet; never mid-packet. Strict alternation: if the
//    selected input is empty the block waits (out_tvalid drops); the other input
//    is never taken out of turn. Unselected input fills its buffer then stalls.
//  - Counters (advance on beat loaded into output register):
//    beat_cnt 0..PACKET_SIZE-1, pkt_cnt 0..PP_GROUP-1, frame_beat 0..FRAME_SIZE-1,
//    each wraps to 0. tlast=(beat_cnt==PACKET_SIZE-1); tuser=(frame_beat==0).
//  - frame_count +1 on output transfer (valid&&ready) of beat with
//    frame_beat==FRAME_SIZE-1; wraps 2^32-1 -> 0.
//  - Simultaneous load and drain of the output register: both occur same cycle,
//    no bubble. Simultaneous accept of in1 and in2 allowed.
//  - PACKET_SIZE=1 / PP_GROUP=1: tlast every beat / switch every packet.
//  - Illegal parameters (any <1, FRAME_SIZE % PACKET_SIZE != 0): elaboration error.
// STRUCTURE
//  - Package pp_stream_pkg: state encoding localparams (S_IN1, S_IN2), counter
//    width functions via $clog2 of PACKET_SIZE/PP_GROUP/FRAME_SIZE.
//  - Sub-module axis_skid_buffer #(DW), instantiated once per input.
//  - Top: FSM, three counters, output register, frame_count.
// TESTING
//  1 Both inputs streaming, out_tready=1, defaults: output order
//    A0 A1 A2 A3 B0 B1 B2 B3 A4..; tlast on every 2nd beat; tuser on beat 0, 256.
//  2 Only in1 valid: 4 beats out, then out_tvalid=0; in2_tready stays 1, in1
//    buffer fills, in1_tready=0 after 2 more beats; no data loss on resume.
//  3 out_tready toggled randomly 50%: tdata/tlast/tuser stable while stalled;
//    output sequence identical to scenario 1.
//  4 512 beats output: frame_count=2; force frame_count=32'hFFFF_FFFF, one frame
//    -> 0.
//  5 resetn=0 mid-packet (beat_cnt=1) for 1 cycle: next output is in1's next
//    beat, tuser=1, tlast=0, frame_count=0.
//  6 PACKET_SIZE=1, PP_GROUP=1: strict A B A B alternation, tlast=1 every beat.

Source files
------------

// File: rtl/pp_stream_pkg.sv
// Shared types and helpers for the ping-pong stream merger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_t   : which input the merger is currently draining
//   cnt_width : counter width for a modulus-n counter (minimum 1 bit)
package pp_stream_pkg;

  typedef enum logic [0:0] {
    S_IN1 = 1'b0,
    S_IN2 = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_stream_merger_if.sv
// AXI-stream style bundle: data, valid/ready handshake, packet-last and frame-start flags.
// Latency: n/a (wires only).
// Backpressure: tready from the slave side; master holds payload while tvalid && !tready.
//   master : drives tdata/tvalid/tlast/tuser, samples tready
//   slave  : samples tdata/tvalid/tlast/tuser, drives tready
interface pp_stream_merger_if #(
  parameter int DW = 128
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer; an empty buffer passes the upstream beat straight through.
// Latency: 0 cycles when empty, otherwise beats leave in arrival order.
// Backpressure: up_ready is registered and low only while both entries are occupied.
//   clk, resetn          : clock, synchronous active-low reset
//   up_data/valid/ready  : upstream side
//   dn_data/valid/ready  : downstream side (dn_valid may depend on up_valid combinationally)
module axis_skid_buffer #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] up_data,
  input  logic          up_valid,
  output logic          up_ready,
  output logic [DW-1:0] dn_data,
  output logic          dn_valid,
  input  logic          dn_ready
);

  logic [DW-1:0] mem [2];
  logic [1:0]    cnt;
  logic [1:0]    cnt_nxt;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic          bypass;

  assign up_ready = ready_q;
  assign push     = up_valid && ready_q;
  assign empty    = (cnt == 2'd0);
  assign dn_valid = empty ? push : 1'b1;
  assign dn_data  = empty ? up_data : mem[rd_ptr];
  assign pop      = dn_valid && dn_ready;
  // A beat that arrives into an empty buffer and leaves the same cycle is never stored.
  assign bypass   = empty && push && pop;
  assign cnt_nxt  = cnt + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt != 2'd2);
      if (push && !bypass) wr_ptr <= ~wr_ptr;
      if (pop && !empty)   rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= up_data;
  end

endmodule

// File: rtl/pp_stream_merger.sv
// Merges two streams in ping-pong order (PP_GROUP packets of PACKET_SIZE beats each), adds tlast/tuser, counts frames.
// Latency: 1 cycle from input accept to axis_out.tvalid; 1 beat/cycle sustained.
// Backpressure: output register stalls on !tready; each input has a 2-entry skid, the idle input fills then stalls.
//   clk, resetn  : clock, synchronous active-low reset
//   axis_in1/2   : input streams (tlast/tuser ignored)
//   axis_out     : merged stream, tlast = last beat of packet, tuser = first beat of frame
//   frame_count  : completed output frames, wraps at 2^32
module pp_stream_merger
  import pp_stream_pkg::*;
#(
  parameter int DW          = 128,
  parameter int PP_GROUP    = 2,
  parameter int PACKET_SIZE = 2,
  parameter int FRAME_SIZE  = 256
) (
  input  logic               clk,
  input  logic               resetn,
  pp_stream_merger_if.slave  axis_in1,
  pp_stream_merger_if.slave  axis_in2,
  pp_stream_merger_if.master axis_out,
  output logic [31:0]        frame_count
);

  if (PACKET_SIZE < 1 || PP_GROUP < 1 || FRAME_SIZE < 1) begin : g_bad_range
    $error("pp_stream_merger: PACKET_SIZE, PP_GROUP and FRAME_SIZE must all be >= 1");
  end else if (FRAME_SIZE % PACKET_SIZE != 0) begin : g_bad_frame
    $error("pp_stream_merger: FRAME_SIZE must be a multiple of PACKET_SIZE");
  end

  localparam int BW = cnt_width(PACKET_SIZE);
  localparam int PW = cnt_width(PP_GROUP);
  localparam int FW = cnt_width(FRAME_SIZE);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(PACKET_SIZE - 1);
  localparam logic [PW-1:0] PKT_MAX   = PW'(PP_GROUP - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_SIZE - 1);

  logic [DW-1:0] b1_data, b2_data, sel_data;
  logic          b1_valid, b2_valid, b1_ready, b2_ready, sel_valid;
  logic          load, xfer;
  state_t        state, state_nxt, sel;

  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] pkt_cnt;
  logic [FW-1:0] frame_beat;
  logic          beat_last, pkt_last, frame_last;

  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_user;
  logic          out_eof;      // beat in the output register closes a frame
  logic          out_grp_end;  // beat in the output register closes a ping-pong group
  logic [31:0]   frame_cnt_q;

  axis_skid_buffer #(.DW(DW)) u_skid_in1 (
    .clk      (clk),
    .resetn   (resetn),
    .up_data  (axis_in1.tdata),
    .up_valid (axis_in1.tvalid),
    .up_ready (axis_in1.tready),
    .dn_data  (b1_data),
    .dn_valid (b1_valid),
    .dn_ready (b1_ready)
  );

  axis_skid_buffer #(.DW(DW)) u_skid_in2 (
    .clk      (clk),
    .resetn   (resetn),
    .up_data  (axis_in2.tdata),
    .up_valid (axis_in2.tvalid),
    .up_ready (axis_in2.tready),
    .dn_data  (b2_data),
    .dn_valid (b2_valid),
    .dn_ready (b2_ready)
  );

  assign beat_last  = (beat_cnt == BEAT_MAX);
  assign pkt_last   = (pkt_cnt == PKT_MAX);
  assign frame_last = (frame_beat == FRAME_MAX);
  assign xfer       = out_valid && axis_out.tready;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IN1;
    else         state <= state_nxt;
  end

  // The state flips when the group-closing beat leaves the output register, but once
  // that beat is loaded the next load must already come from the other input, so the
  // load select looks one beat ahead of the state register.
  always_comb begin
    state_nxt = state;
    sel       = state;
    if (out_valid && out_grp_end) sel = (state == S_IN1) ? S_IN2 : S_IN1;
    if (xfer && out_grp_end) state_nxt = sel;
  end

  always_comb begin
    sel_valid = (sel == S_IN1) ? b1_valid : b2_valid;
    sel_data  = (sel == S_IN1) ? b1_data  : b2_data;
    load      = sel_valid && (!out_valid || axis_out.tready);
    b1_ready  = load && (sel == S_IN1);
    b2_ready  = load && (sel == S_IN2);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
      frame_beat <= '0;
    end else if (load) begin
      beat_cnt   <= beat_last ? '0 : beat_cnt + 1'b1;
      frame_beat <= frame_last ? '0 : frame_beat + 1'b1;
      if (beat_last) pkt_cnt <= pkt_last ? '0 : pkt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_user    <= 1'b0;
      out_eof     <= 1'b0;
      out_grp_end <= 1'b0;
    end else if (load) begin
      out_data    <= sel_data;
      out_valid   <= 1'b1;
      out_last    <= beat_last;
      out_user    <= (frame_beat == '0);
      out_eof     <= frame_last;
      out_grp_end <= beat_last && pkt_last;
    end else if (axis_out.tready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)             frame_cnt_q <= 32'd0;
    else if (xfer && out_eof) frame_cnt_q <= frame_cnt_q + 32'd1;
  end

  assign axis_out.tdata  = out_data;
  assign axis_out.tvalid = out_valid;
  assign axis_out.tlast  = out_last;
  assign axis_out.tuser  = out_user;
  assign frame_count     = frame_cnt_q;

endmodule

// File: tb/tb_pp_stream_merger.sv
// Directed bench for pp_stream_merger: default build (A) plus a PACKET_SIZE=1/PP_GROUP=1/FRAME_SIZE=4 build (B).
// Expected output beat n is computed from the ping-pong rule over per-input source indices.
module tb_pp_stream_merger;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pp_stream_merger_if #(.DW(128)) a_in1 ();
  pp_stream_merger_if #(.DW(128)) a_in2 ();
  pp_stream_merger_if #(.DW(128)) a_out ();
  pp_stream_merger_if #(.DW(128)) b_in1 ();
  pp_stream_merger_if #(.DW(128)) b_in2 ();
  pp_stream_merger_if #(.DW(128)) b_out ();
  logic [31:0] fc_a, fc_b;

  pp_stream_merger #(.DW(128), .PP_GROUP(2), .PACKET_SIZE(2), .FRAME_SIZE(256)) dut_a (
    .clk(clk), .resetn(resetn), .axis_in1(a_in1), .axis_in2(a_in2), .axis_out(a_out), .frame_count(fc_a)
  );
  pp_stream_merger #(.DW(128), .PP_GROUP(1), .PACKET_SIZE(1), .FRAME_SIZE(4)) dut_b (
    .clk(clk), .resetn(resetn), .axis_in1(b_in1), .axis_in2(b_in2), .axis_out(b_out), .frame_count(fc_b)
  );

  int vecs, errs, cyc;
  int idx_a1, idx_a2, idx_b1, idx_b2;   // next source index presented on each input
  int base_a1, base_a2, base_b1, base_b2; // source index of the first beat after the last reset
  int n_a, n_b;                          // output beats transferred since the last reset
  logic en_a1, en_a2, rnd_rdy;

  function automatic logic [127:0] mk(input int src, input int idx);
    return {88'h0, 8'(src), 32'(idx)};
  endfunction

  function automatic void exp_beat(input int n, input int b1, input int b2, input int ps,
                                   input int pg, input int fs, output logic [127:0] d,
                                   output logic l, output logic u);
    int grp, g, src, idx;
    grp = ps * pg;
    g   = n / grp;
    src = (g % 2 == 0) ? 1 : 2;
    idx = (g / 2) * grp + n % grp + ((src == 1) ? b1 : b2);
    d   = mk(src, idx);
    l   = (n % ps) == (ps - 1);
    u   = (n % fs) == 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic [127:0] ed;
    logic el, eu, acc_a1, acc_a2, acc_b1, acc_b2, xo_a, xo_b;
    a_in1.tdata = mk(1, idx_a1); a_in1.tvalid = en_a1;
    a_in2.tdata = mk(2, idx_a2); a_in2.tvalid = en_a2;
    a_out.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    b_in1.tdata = mk(1, idx_b1); b_in1.tvalid = 1'b1;
    b_in2.tdata = mk(2, idx_b2); b_in2.tvalid = 1'b1;
    b_out.tready = 1'b1;
    #4;
    if (resetn && a_out.tvalid) begin
      exp_beat(n_a, base_a1, base_a2, 2, 2, 256, ed, el, eu);
      chk("a_tdata", a_out.tdata, ed);
      chk("a_tlast", 128'(a_out.tlast), 128'(el));
      chk("a_tuser", 128'(a_out.tuser), 128'(eu));
    end
    if (resetn && b_out.tvalid) begin
      exp_beat(n_b, base_b1, base_b2, 1, 1, 4, ed, el, eu);
      chk("b_tdata", b_out.tdata, ed);
      chk("b_tlast", 128'(b_out.tlast), 128'(el));
      chk("b_tuser", 128'(b_out.tuser), 128'(eu));
    end
    acc_a1 = resetn && a_in1.tvalid && a_in1.tready;
    acc_a2 = resetn && a_in2.tvalid && a_in2.tready;
    acc_b1 = resetn && b_in1.tvalid && b_in1.tready;
    acc_b2 = resetn && b_in2.tvalid && b_in2.tready;
    xo_a   = resetn && a_out.tvalid && a_out.tready;
    xo_b   = resetn && b_out.tvalid && b_out.tready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_a1) idx_a1++;
    if (acc_a2) idx_a2++;
    if (acc_b1) idx_b1++;
    if (acc_b2) idx_b2++;
    if (xo_a) n_a++;
    if (xo_b) n_b++;
    if (!resetn) begin
      n_a = 0; base_a1 = idx_a1; base_a2 = idx_a2;
      n_b = 0; base_b1 = idx_b1; base_b2 = idx_b2;
    end
  endtask

  task automatic wait_n_a(input int target, input int budget);
    int k;
    k = 0;
    while (n_a < target && k < budget) begin
      tick();
      k++;
    end
    chk("a_beats_reached", 128'(n_a), 128'(target));
  endtask

  initial begin
    vecs = 0; errs = 0; cyc = 0;
    idx_a1 = 0; idx_a2 = 0; idx_b1 = 0; idx_b2 = 0;
    base_a1 = 0; base_a2 = 0; base_b1 = 0; base_b2 = 0;
    n_a = 0; n_b = 0;
    en_a1 = 1'b0; en_a2 = 1'b0; rnd_rdy = 1'b0;
    a_in1.tlast = 1'b0; a_in1.tuser = 1'b0; a_in2.tlast = 1'b0; a_in2.tuser = 1'b0;
    b_in1.tlast = 1'b0; b_in1.tuser = 1'b0; b_in2.tlast = 1'b0; b_in2.tuser = 1'b0;
    resetn = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_in1_tready", 128'(a_in1.tready), 128'(1'b0));
    chk("rst_in2_tready", 128'(a_in2.tready), 128'(1'b0));
    chk("rst_out_tvalid", 128'(a_out.tvalid), 128'(1'b0));
    chk("rst_out_tlast",  128'(a_out.tlast),  128'(1'b0));
    chk("rst_out_tuser",  128'(a_out.tuser),  128'(1'b0));
    chk("rst_out_tdata",  a_out.tdata,        128'h0);
    chk("rst_frame_count", 128'(fc_a),        128'h0);
    resetn = 1'b1;
    tick();
    chk("post_rst_in1_tready", 128'(a_in1.tready), 128'(1'b1));
    chk("post_rst_in2_tready", 128'(a_in2.tready), 128'(1'b1));

    // Only input 1 valid: one group of 4 beats leaves, then in1 fills its buffer (2 more) and stalls
    en_a1 = 1'b1;
    repeat (12) tick();
    chk("only1_out_beats", 128'(n_a), 128'd4);
    chk("only1_out_tvalid", 128'(a_out.tvalid), 128'(1'b0));
    chk("only1_in1_accepted", 128'(idx_a1), 128'd6);
    chk("only1_in1_tready", 128'(a_in1.tready), 128'(1'b0));
    chk("only1_in2_tready", 128'(a_in2.tready), 128'(1'b1));

    // Both inputs streaming, full-rate output; order continues B0..B3 then buffered A4, A5
    en_a2 = 1'b1;
    wait_n_a(60, 200);

    // Random output stalls; held beats are checked against the same expected beat every cycle
    rnd_rdy = 1'b1;
    repeat (300) tick();
    rnd_rdy = 1'b0;

    // Frame counting and 2^32 wrap
    wait_n_a(512, 2000);
    chk("frames_after_512", 128'(fc_a), 128'd2);
    force dut_a.frame_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut_a.frame_cnt_q;
    chk("frame_count_forced", 128'(fc_a), 128'hFFFF_FFFF);
    wait_n_a(768, 600);
    chk("frame_count_wrap", 128'(fc_a), 128'h0);

    // Reset while the output register holds the first beat of a packet (beat_cnt==1)
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    begin
      int k;
      k = 0;
      while (!a_out.tvalid && k < 10) begin
        tick();
        k++;
      end
    end
    chk("rst_mid_tvalid", 128'(a_out.tvalid), 128'(1'b1));
    chk("rst_mid_tdata", a_out.tdata, mk(1, base_a1));
    chk("rst_mid_tuser", 128'(a_out.tuser), 128'(1'b1));
    chk("rst_mid_tlast", 128'(a_out.tlast), 128'(1'b0));
    chk("rst_mid_frame_count", 128'(fc_a), 128'h0);
    wait_n_a(20, 100);

    // Single-beat packets, single-packet groups: A B A B with tlast on every beat
    chk("b_frame_count", 128'(fc_b), 128'(n_b / 4));
    chk("b_beats_flowing", 128'(n_b >= 20), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
